regfile_scoreboard: RTL
=======================

Name: regfile_scoreboard

Overview:
- Tracks in-flight writes to the eight architectural registers that feed the two register read ports.
- Tells decode when a source or destination register is still pending writeback, and stalls issue until it is safe.
- Sits between decode (issue side) and writeback (retire side).
- Sequences when read-port data selected by the register read mux is valid to consume.

Parameters:
- NUM_REGS, 8, number of architectural registers; fixes select width at 3 bits.
- CNT_W, 2, width of each per-register pending-write counter; maximum in flight per register = 2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous clear of all pending state (branch/exception squash).
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_wr_en  input  1  instruction writes a register.
- issue_dst  input  3  destination register select.
- src1_sel  input  3  read port 1 register select.
- src1_used  input  1  instruction actually reads src1.
- src2_sel  input  3  read port 2 register select.
- src2_used  input  1  instruction actually reads src2.
- wb_valid  input  1  writeback completes this cycle.
- wb_dst  input  3  register written back.
- stall  output  1  combinational; issue must hold.
- issue_ack  output  1  combinational; issue_valid && !stall.
- busy_vec  output  8  registered; bit i = counter[i] != 0.
- err  output  1  registered, sticky; retire to a register with zero pending writes.

Behaviour:
- Reset (rst_n low, asynchronous): all counters = 0, busy_vec = 8'h00, err = 0. stall and issue_ack follow directly, so both are 0 unless issue_valid is high.
- stall = issue_valid && (hazard1 || hazard2 || sat).
  - hazard1 = src1_used && cnt[src1_sel] != 0.
  - hazard2 = src2_used && cnt[src2_sel] != 0.
  - sat = issue_wr_en && cnt[issue_dst] == 2^CNT_W-1.
- stall uses current (registered) counters only; a same-cycle wb_valid does not clear stall that cycle. Hazards release one cycle after writeback.
- Counter update per register r, each clock edge:
  - inc = issue_ack && issue_wr_en && issue_dst == r.
  - dec = wb_valid && wb_dst == r && cnt[r] != 0.
  - inc && dec: unchanged. inc only: +1. dec only: -1.
- Counters never wrap. Saturation is prevented by sat; underflow is prevented by the cnt != 0 guard.
- wb_valid to a register with cnt == 0: no counter change, err set to 1 and held until reset.
- An instruction whose own dst equals its src is handled normally: stall if the src is pending; after acceptance the dst counter increments.
- flush has priority over issue and wb in the same cycle: all counters = 0 next cycle. err is not cleared by flush.
- issue_ack is 0 whenever flush is high.
- Reset asserted mid-operation clears everything immediately, regardless of clk.
- busy_vec is updated on the same edge as the counters; it reflects post-update state.
- No multi-cycle latency: issue acceptance is same-cycle; counter effects are visible the next cycle.

Test Plan:
- Reset, then issue_valid=1, src1_sel=3, src1_used=1, issue_wr_en=1, issue_dst=5 -> stall=0, issue_ack=1; next cycle busy_vec=8'h20.
- With R5 pending, issue src2_sel=5, src2_used=1 -> stall=1. Apply wb_valid with wb_dst=5 in that cycle -> stall stays 1 that cycle, 0 the next, busy_vec=8'h00.
- Issue three writes to R2 (CNT_W=2) -> cnt=3, busy_vec=8'h04; a fourth issue to R2 -> stall=1. One writeback to R2 -> fourth accepted the following cycle.
- Same cycle: issue_ack with dst=1 and wb_valid with wb_dst=1, starting from cnt[1]=1 -> cnt[1] stays 1, busy_vec bit1 stays 1.
- wb_valid with wb_dst=6 while busy_vec=0 -> err=1 next cycle and remains 1 after flush; busy_vec stays 8'h00.
- Pending writes to R0 and R7, assert flush together with issue_valid -> issue_ack=0, busy_vec=8'h00 next cycle. Drop rst_n low mid-cycle -> all outputs clear without a clock edge.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - pending-writeback scoreboard for the eight architectural registers
module regfile_scoreboard #(
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 2,
    localparam int SEL_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                issue_valid,
    input  logic                issue_wr_en,
    input  logic [SEL_W-1:0]    issue_dst,
    input  logic [SEL_W-1:0]    src1_sel,
    input  logic                src1_used,
    input  logic [SEL_W-1:0]    src2_sel,
    input  logic                src2_used,
    input  logic                wb_valid,
    input  logic [SEL_W-1:0]    wb_dst,
    output logic                stall,
    output logic                issue_ack,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic                err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                err_q, err_d;
    logic [NUM_REGS-1:0] inc_vec, dec_vec;
    logic                hazard1, hazard2, sat;

    // Hazards look only at registered counters; a same-cycle writeback releases next cycle.
    always_comb begin
        hazard1   = src1_used && (cnt_q[src1_sel] != '0);
        hazard2   = src2_used && (cnt_q[src2_sel] != '0);
        sat       = issue_wr_en && (cnt_q[issue_dst] == CNT_MAX);
        stall     = issue_valid && (hazard1 || hazard2 || sat);
        issue_ack = issue_valid && !stall && !flush;
    end

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        busy_d  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = issue_ack && issue_wr_en && (issue_dst == SEL_W'(r));
            dec_vec[r] = wb_valid && (wb_dst == SEL_W'(r)) && (cnt_q[r] != '0);
            cnt_d[r]   = cnt_q[r];
            if (flush) begin
                cnt_d[r] = '0;
            end else if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
        // Retiring a register with nothing pending is a protocol error; flush does not hide it.
        err_d = err_q || (wb_valid && (cnt_q[wb_dst] == '0));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign busy_vec = busy_q;
    assign err      = err_q;

endmodule
